// File: rtl/handshake_pkg.sv
// Shared types and elaboration-time helpers for the round-robin handshake arbiter.
package handshake_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // A counter still needs one bit even when it only ever holds zero.
  function automatic int counter_width(input int count);
    int w;
    w = clog2(count);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/handshake_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first requester at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   pick_onehot,
  output logic [IDW-1:0] pick_idx,
  output logic           any_req
);

  int   best_dist_s;
  int   best_idx_s;
  int   dist_s;
  logic found_s;

  // Choose the requester with the smallest rotated distance from ptr.
  always_comb begin
    best_dist_s = N;
    best_idx_s  = 0;
    dist_s      = 0;
    found_s     = 1'b0;
    for (int i = 0; i < N; i++) begin
      dist_s = (i + N - int'(ptr)) % N;
      if (req[i] && (dist_s < best_dist_s)) begin
        best_dist_s = dist_s;
        best_idx_s  = i;
        found_s     = 1'b1;
      end else begin
        best_dist_s = best_dist_s;
      end
    end
  end

  // Expand the winning index into the one-hot and encoded forms.
  always_comb begin
    pick_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (found_s && (best_idx_s == i)) begin
        pick_onehot[i] = 1'b1;
      end else begin
        pick_onehot[i] = 1'b0;
      end
    end
    pick_idx = IDW'(best_idx_s);
    any_req  = |req;
  end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready channel among N requesters, with a
// bounded burst per grant and a single registered output stage carrying data plus source ID.
module handshake_rr_arbiter
  import handshake_pkg::*;
#(
  parameter int L     = 8,
  parameter int N     = 4,
  parameter int IDW   = 2,
  parameter int BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*L-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [L-1:0]   out_data,
  output logic [IDW-1:0] out_id,
  output logic [N-1:0]   grant,
  output logic           busy
);

  localparam int             CNTW      = counter_width(BURST);
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BURST - 1);
  localparam logic [IDW-1:0]  LAST_IDX  = IDW'(N - 1);

  arb_state_e     state_r;
  arb_state_e     state_nxt_s;
  logic [IDW-1:0] ptr_r;
  logic [IDW-1:0] owner_r;
  logic [CNTW-1:0] beat_cnt_r;
  logic [N-1:0]   grant_r;
  logic           out_valid_r;
  logic [L-1:0]   out_data_r;
  logic [IDW-1:0] out_id_r;

  logic [N-1:0]   pick_onehot_s;
  logic [IDW-1:0] pick_idx_s;
  logic           any_req_s;
  logic           load_en_s;
  logic           owner_valid_s;
  logic [L-1:0]   owner_data_s;
  logic           beat_s;
  logic           release_s;
  logic [N-1:0]   req_ready_s;
  logic           busy_s;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_pick (
    .req         (req_valid),
    .ptr         (ptr_r),
    .pick_onehot (pick_onehot_s),
    .pick_idx    (pick_idx_s),
    .any_req     (any_req_s)
  );

  // Select the current owner's valid and data without a variable part-select.
  always_comb begin
    owner_valid_s = 1'b0;
    owner_data_s  = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_r == IDW'(i)) begin
        owner_valid_s = req_valid[i];
        owner_data_s  = req_data[i*L +: L];
      end else begin
        owner_valid_s = owner_valid_s;
      end
    end
  end

  // Beat acceptance and release conditions; release never happens while the output is stalled.
  always_comb begin
    load_en_s = !out_valid_r || out_ready;
    if (state_r == ARB_GRANT) begin
      beat_s    = owner_valid_s && load_en_s;
      release_s = (beat_s && (beat_cnt_r == LAST_BEAT)) || (load_en_s && !owner_valid_s);
    end else begin
      beat_s    = 1'b0;
      release_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ARB_GRANT;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        if (release_s) begin
          state_nxt_s = ARB_IDLE;
        end else begin
          state_nxt_s = ARB_GRANT;
        end
      end
      default: state_nxt_s = ARB_IDLE;
    endcase
  end

  // FSM outputs: only the owner sees ready, and only when the output stage can take a beat.
  always_comb begin
    req_ready_s = '0;
    busy_s      = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        req_ready_s = '0;
        busy_s      = 1'b0;
      end
      ARB_GRANT: begin
        busy_s = 1'b1;
        for (int i = 0; i < N; i++) begin
          if (owner_r == IDW'(i)) begin
            req_ready_s[i] = load_en_s;
          end else begin
            req_ready_s[i] = 1'b0;
          end
        end
      end
      default: begin
        req_ready_s = '0;
        busy_s      = 1'b0;
      end
    endcase
  end

  // Arbitration bookkeeping: owner capture, burst count and pointer advance past the owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r      <= '0;
      owner_r    <= '0;
      beat_cnt_r <= '0;
      grant_r    <= '0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (any_req_s) begin
            owner_r    <= pick_idx_s;
            grant_r    <= pick_onehot_s;
            beat_cnt_r <= '0;
          end else begin
            grant_r <= '0;
          end
        end
        ARB_GRANT: begin
          if (beat_s) begin
            beat_cnt_r <= beat_cnt_r + CNTW'(1);
          end else begin
            beat_cnt_r <= beat_cnt_r;
          end
          if (release_s) begin
            grant_r <= '0;
            ptr_r   <= (owner_r == LAST_IDX) ? '0 : owner_r + IDW'(1);
          end else begin
            grant_r <= grant_r;
          end
        end
        default: begin
          grant_r <= '0;
        end
      endcase
    end
  end

  // Output stage: reload on a beat, empty when drained, otherwise hold steady.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_id_r    <= '0;
    end else if (beat_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= owner_data_s;
      out_id_r    <= owner_r;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign req_ready = req_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_id    = out_id_r;
  assign grant     = grant_r;
  assign busy      = busy_s;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Self-checking bench: two arbiters (BURST=4 and BURST=1) against a cycle-level reference model.
module tb_handshake_rr_arbiter;

  localparam int L   = 8;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   rv   [2];
  logic [N*L-1:0] rd   [2];
  logic           ordy [2];
  logic [N-1:0]   rr   [2];
  logic           ov   [2];
  logic [L-1:0]   od   [2];
  logic [IDW-1:0] oid  [2];
  logic [N-1:0]   gr   [2];
  logic           bz   [2];

  int total;
  int bad;

  // reference model state
  int         bst     [2];
  bit         m_busy  [2];
  int         m_owner [2];
  int         m_ptr   [2];
  int         m_cnt   [2];
  bit         m_ov    [2];
  logic [7:0] m_od    [2];
  int         m_oid   [2];

  logic [N-1:0] hold [2];
  logic [7:0]   script_q [$];
  int           acc_id0 [$];
  logic [7:0]   acc_d0 [$];
  int           acc_id1 [$];

  handshake_rr_arbiter #(.L(L), .N(N), .IDW(IDW), .BURST(4)) dut_b4 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_data(rd[0]), .req_ready(rr[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_id(oid[0]),
    .grant(gr[0]), .busy(bz[0])
  );

  handshake_rr_arbiter #(.L(L), .N(N), .IDW(IDW), .BURST(1)) dut_b1 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_data(rd[1]), .req_ready(rr[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_id(oid[1]),
    .grant(gr[1]), .busy(bz[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_busy[u]  = 1'b0;
      m_owner[u] = 0;
      m_ptr[u]   = 0;
      m_cnt[u]   = 0;
      m_ov[u]    = 1'b0;
      m_od[u]    = 8'h00;
      m_oid[u]   = 0;
    end
  endtask

  // One clock: check outputs at negedge, predict the edge, then let requesters react.
  task automatic tick();
    logic [N-1:0] hs [2];
    bit           n_busy  [2];
    int           n_owner [2];
    int           n_ptr   [2];
    int           n_cnt   [2];
    bit           n_ov    [2];
    logic [7:0]   n_od    [2];
    int           n_oid   [2];
    bit           ld;
    bit           bt;
    logic [N-1:0] own_hot;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      ld      = !m_ov[u] || ordy[u];
      own_hot = m_busy[u] ? (4'b0001 << m_owner[u]) : 4'b0000;
      chk($sformatf("u%0d grant", u), 32'(gr[u]), 32'(own_hot));
      chk($sformatf("u%0d req_ready", u), 32'(rr[u]), ld ? 32'(own_hot) : 32'd0);
      chk($sformatf("u%0d busy", u), 32'(bz[u]), 32'(m_busy[u]));
      chk($sformatf("u%0d out_valid", u), 32'(ov[u]), 32'(m_ov[u]));
      chk($sformatf("u%0d out_data", u), 32'(od[u]), 32'(m_od[u]));
      chk($sformatf("u%0d out_id", u), 32'(oid[u]), 32'(m_oid[u]));
      if (ov[u] && ordy[u]) begin
        if (u == 0) begin
          acc_id0.push_back(int'(oid[0]));
          acc_d0.push_back(od[0]);
        end else begin
          acc_id1.push_back(int'(oid[1]));
        end
      end
      n_busy[u] = m_busy[u]; n_owner[u] = m_owner[u]; n_ptr[u] = m_ptr[u];
      n_cnt[u]  = m_cnt[u];  n_ov[u]    = m_ov[u];    n_od[u]  = m_od[u];
      n_oid[u]  = m_oid[u];
      hs[u]     = '0;
      if (m_ov[u] && ordy[u]) n_ov[u] = 1'b0;
      if (!m_busy[u]) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr[u] + k) % N;
          if (!n_busy[u] && rv[u][c]) begin
            n_busy[u] = 1'b1; n_owner[u] = c; n_cnt[u] = 0;
          end
        end
      end else begin
        bt = rv[u][m_owner[u]] && ld;
        if (bt) begin
          hs[u][m_owner[u]] = 1'b1;
          n_ov[u]  = 1'b1;
          n_od[u]  = rd[u][m_owner[u]*L +: L];
          n_oid[u] = m_owner[u];
          n_cnt[u] = m_cnt[u] + 1;
        end
        if ((bt && (m_cnt[u] == bst[u] - 1)) || (ld && !rv[u][m_owner[u]])) begin
          n_busy[u] = 1'b0;
          n_ptr[u]  = (m_owner[u] + 1) % N;
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        m_busy[u] = n_busy[u]; m_owner[u] = n_owner[u]; m_ptr[u] = n_ptr[u];
        m_cnt[u]  = n_cnt[u];  m_ov[u]    = n_ov[u];    m_od[u]  = n_od[u];
        m_oid[u]  = n_oid[u];
      end
    end else begin
      model_reset();
      hs[0] = '0;
      hs[1] = '0;
    end
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < N; i++) begin
        if (hs[u][i]) begin
          if (u == 0 && i == 0 && script_q.size() > 0) rd[0][7:0] = script_q.pop_front();
          else if (hold[u][i]) rd[u][i*L +: L] = 8'($urandom);
          else rv[u][i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int first;
    int obs_i;
    clk   = 1'b0;
    rst   = 1'b1;
    total = 0;
    bad   = 0;
    bst[0] = 4;
    bst[1] = 1;
    for (int u = 0; u < 2; u++) begin
      rv[u] = 4'h0; rd[u] = 32'($urandom); ordy[u] = 1'b1; hold[u] = 4'hF;
    end
    model_reset();
    #2 rst = 1'b0;

    // T1: reset held with all requesters valid, then release
    rv[0] = 4'hF;
    rv[1] = 4'hF;
    repeat (3) tick();
    rst = 1'b1;
    acc_id0.delete();
    tick();
    chk("t1 grant after release", 32'(gr[0]), 32'h1);

    // T2: full contention, BURST=4
    repeat (32) tick();
    for (int k = 0; k < 20; k++) begin
      obs_i = (k < acc_id0.size()) ? acc_id0[k] : -1;
      chk($sformatf("t2 id seq %0d", k), 32'(obs_i), 32'((k / 4) % 4));
    end

    // T3: backpressure on a scripted stream A5,5A,C3
    rv[0] = 4'h0; rv[1] = 4'h0; hold[0] = 4'h0; hold[1] = 4'h0;
    repeat (5) tick();
    rd[0][7:0] = 8'hA5;
    rv[0]      = 4'b0001;
    script_q   = '{8'h5A, 8'hC3};
    acc_d0.delete();
    tick();
    tick();
    ordy[0] = 1'b0;
    repeat (3) begin
      tick();
      chk("t3 held data", 32'(od[0]), 32'hA5);
      chk("t3 ready low", 32'(rr[0]), 32'h0);
    end
    ordy[0] = 1'b1;
    repeat (8) tick();
    chk("t3 beat count", 32'(acc_d0.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      logic [7:0] exp_b [3];
      exp_b = '{8'hA5, 8'h5A, 8'hC3};
      obs_i = (k < acc_d0.size()) ? int'(acc_d0[k]) : -1;
      chk($sformatf("t3 order %0d", k), 32'(obs_i), 32'(exp_b[k]));
    end

    // T4: early release moves grant after one bubble, pointer past old owner
    rd[0]    = 32'($urandom);
    rv[0][2] = 1'b1;
    tick();
    rv[0][1] = 1'b1;
    repeat (3) tick();
    chk("t4 grant to req1", 32'(gr[0]), 32'h2);
    rv[0][0] = 1'b1;
    rv[0][3] = 1'b1;
    repeat (3) tick();
    chk("t4 req3 wins tie", 32'(gr[0]), 32'h8);
    repeat (12) tick();

    // T5: BURST=1 with only req3 and req0 valid alternates owners
    first   = (m_ptr[1] == 0) ? 0 : 3;
    rv[1]   = 4'b1001;
    hold[1] = 4'b1001;
    acc_id1.delete();
    repeat (16) tick();
    for (int k = 0; k < 4; k++) begin
      obs_i = (k < acc_id1.size()) ? acc_id1[k] : -1;
      chk($sformatf("t5 id %0d", k), 32'(obs_i), 32'((k % 2 == 0) ? first : 3 - first));
    end
    rv[1]   = 4'h0;
    hold[1] = 4'h0;

    // T6: reset in the middle of a burst
    rd[0]   = 32'($urandom);
    rv[0]   = 4'hF;
    hold[0] = 4'hF;
    for (int k = 0; k < 10 && !ov[0]; k++) tick();
    chk("t6 reached out_valid", 32'(ov[0]), 32'h1);
    rst = 1'b0;
    #1;
    chk("t6 out_valid cleared", 32'(ov[0]), 32'h0);
    chk("t6 busy cleared", 32'(bz[0]), 32'h0);
    chk("t6 grant cleared", 32'(gr[0]), 32'h0);
    chk("t6 ready cleared", 32'(rr[0]), 32'h0);
    model_reset();
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("t6 ptr back to 0", 32'(gr[0]), 32'h1);

    // Random traffic with random backpressure and burst lengths
    repeat (400) begin
      for (int u = 0; u < 2; u++) begin
        ordy[u] = ($urandom_range(0, 3) != 0);
        hold[u] = 4'($urandom);
        for (int i = 0; i < N; i++) begin
          if (!rv[u][i] && ($urandom_range(0, 2) == 0)) begin
            rv[u][i]         = 1'b1;
            rd[u][i*L +: L]  = 8'($urandom);
          end
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
